chunked_rca_adder: RTL and testbench

Parametrised multi-cycle ripple-carry adder; successor to the fixed 8-bit combinational RCA. Adds two WIDTH-bit operands plus carry-in, CHUNK bits per clock, through one shared CHUNK-bit ripple slice, so wide adds stay off the critical path. Valid/ready handshakes on input and output let it sit between datapath stages in a streaming arithmetic pipeline.

---
 rtl/chunked_rca_pkg.sv | 19 +
 rtl/chunked_rca_adder_chunk.sv | 28 ++
 rtl/chunked_rca_adder.sv | 154 +++++++++++++++
 tb/tb_chunked_rca_adder.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/chunked_rca_pkg.sv
// Shared types and constants for the chunked ripple-carry adder.
// Optional subtract support is enabled with the CHUNKED_RCA_SUB_EN macro (see top).
package chunked_rca_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int DEF_WIDTH = 32;
  localparam int DEF_CHUNK = 8;

  // True when CHUNK is in range and divides WIDTH evenly.
  function automatic bit chunk_cfg_ok(input int width, input int chunk);
    return (chunk >= 1) && (chunk <= width) && ((width % chunk) == 0);
  endfunction

endpackage

// File: rtl/chunked_rca_adder_chunk.sv
// Combinational CHUNK-bit ripple slice built from full-adder cells; also
// exposes the carry into its MSB so the caller can derive signed overflow.
module rca_chunk #(
  parameter int CHUNK = 8
) (
  input  logic [CHUNK-1:0] a,
  input  logic [CHUNK-1:0] b,
  input  logic             ci,
  output logic [CHUNK-1:0] s,
  output logic             co,
  output logic             c_msb_in
);

  logic [CHUNK:0] c;

  assign c[0] = ci;

  generate
    for (genvar gi = 0; gi < CHUNK; gi++) begin : g_fa
      assign s[gi]   = a[gi] ^ b[gi] ^ c[gi];
      assign c[gi+1] = (a[gi] & b[gi]) | (c[gi] & (a[gi] ^ b[gi]));
    end
  endgenerate

  assign co       = c[CHUNK];
  assign c_msb_in = c[CHUNK-1];

endmodule

// File: rtl/chunked_rca_adder.sv
// Multi-cycle ripple-carry adder: WIDTH-bit add, CHUNK bits per clock through one slice.
// Define CHUNKED_RCA_SUB_EN to add a 'sub' input selecting A-B.
module chunked_rca_adder
  import chunked_rca_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int CHUNK = DEF_CHUNK
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
`ifdef CHUNKED_RCA_SUB_EN
  input  logic             sub,
`endif
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int NCHUNK = WIDTH / CHUNK;
  localparam int IDXW   = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

  generate
    if (!chunk_cfg_ok(WIDTH, CHUNK)) begin : g_bad_cfg
      $error("chunked_rca_adder: WIDTH must be a multiple of CHUNK with 1 <= CHUNK <= WIDTH");
    end
  endgenerate

  state_t            state_reg, state_next;
  logic [WIDTH-1:0]  a_reg, b_reg;
  logic              carry_reg;
  logic [IDXW-1:0]   idx_reg;
  logic              cout_reg, ovf_reg;
  logic              load, step, last;

  logic [WIDTH-1:0]  b_load;
  logic              c_load;

`ifdef CHUNKED_RCA_SUB_EN
  // Two's-complement subtract: invert B and force the initial carry.
  assign b_load = sub ? ~b : b;
  assign c_load = sub ? 1'b1 : cin;
`else
  assign b_load = b;
  assign c_load = cin;
`endif

  // Operand slice selection: one CHUNK-wide lane per chunk index.
  logic [CHUNK-1:0] a_lane [NCHUNK];
  logic [CHUNK-1:0] b_lane [NCHUNK];
  logic [CHUNK-1:0] a_slice, b_slice, s_slice;
  logic             slice_co, slice_c_msb;

  generate
    for (genvar gi = 0; gi < NCHUNK; gi++) begin : g_lane
      assign a_lane[gi] = a_reg[gi*CHUNK +: CHUNK];
      assign b_lane[gi] = b_reg[gi*CHUNK +: CHUNK];
    end
  endgenerate

  assign a_slice = a_lane[idx_reg];
  assign b_slice = b_lane[idx_reg];
  assign last    = (idx_reg == IDXW'(NCHUNK - 1));

  rca_chunk #(
    .CHUNK(CHUNK)
  ) u_slice (
    .a        (a_slice),
    .b        (b_slice),
    .ci       (carry_reg),
    .s        (s_slice),
    .co       (slice_co),
    .c_msb_in (slice_c_msb)
  );

  always_comb begin
    state_next = state_reg;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    load       = 1'b0;
    step       = 1'b0;
    case (state_reg)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          load       = 1'b1;
          state_next = BUSY;
        end
      end
      BUSY: begin
        step = 1'b1;
        if (last) state_next = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= IDLE;
      a_reg     <= '0;
      b_reg     <= '0;
      carry_reg <= 1'b0;
      idx_reg   <= '0;
      cout_reg  <= 1'b0;
      ovf_reg   <= 1'b0;
    end else begin
      state_reg <= state_next;
      if (load) begin
        a_reg     <= a;
        b_reg     <= b_load;
        carry_reg <= c_load;
        idx_reg   <= '0;
      end else if (step) begin
        carry_reg <= slice_co;
        idx_reg   <= last ? '0 : idx_reg + IDXW'(1);
        if (last) begin
          cout_reg <= slice_co;
          ovf_reg  <= slice_c_msb ^ slice_co;
        end
      end
    end
  end

  // Each sum lane captures the slice result only on its own BUSY cycle.
  logic [CHUNK-1:0] sum_lane_reg [NCHUNK];

  generate
    for (genvar gi = 0; gi < NCHUNK; gi++) begin : g_sum
      always_ff @(posedge clk) begin
        if (rst) begin
          sum_lane_reg[gi] <= '0;
        end else if (step && (idx_reg == IDXW'(gi))) begin
          sum_lane_reg[gi] <= s_slice;
        end
      end
      assign sum[gi*CHUNK +: CHUNK] = sum_lane_reg[gi];
    end
  endgenerate

  assign cout = cout_reg;
  assign ovf  = ovf_reg;

endmodule

// File: tb/tb_chunked_rca_adder.sv
// Self-checking bench for chunked_rca_adder (32/8 main instance, 8/1 secondary).
// Subtract cases run when CHUNKED_RCA_SUB_EN is defined.
module tb_chunked_rca_adder;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_ready, out_valid, out_ready;
  logic [31:0] a, b, sum;
  logic        cin, cout, ovf;
  logic        sub;

  logic        s_in_valid, s_in_ready, s_out_valid, s_out_ready;
  logic [7:0]  s_a, s_b, s_sum;
  logic        s_cin, s_cout, s_ovf;
  logic        s_sub;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  chunked_rca_adder #(.WIDTH(32), .CHUNK(8)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .cin(cin),
`ifdef CHUNKED_RCA_SUB_EN
    .sub(sub),
`endif
    .out_valid(out_valid), .out_ready(out_ready),
    .sum(sum), .cout(cout), .ovf(ovf)
  );

  chunked_rca_adder #(.WIDTH(8), .CHUNK(1)) dut_narrow (
    .clk(clk), .rst(rst), .in_valid(s_in_valid), .in_ready(s_in_ready),
    .a(s_a), .b(s_b), .cin(s_cin),
`ifdef CHUNKED_RCA_SUB_EN
    .sub(s_sub),
`endif
    .out_valid(s_out_valid), .out_ready(s_out_ready),
    .sum(s_sum), .cout(s_cout), .ovf(s_ovf)
  );

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic        cin;
    logic [31:0] sum;
    logic        cout;
    logic        ovf;
  } vec_t;

  // Reference: plain wide arithmetic; returns {ovf, cout, sum}.
  function automatic logic [33:0] model(input logic [31:0] x, input logic [31:0] y,
                                        input logic c, input logic sb);
    logic [31:0] yy;
    logic        cc;
    logic [32:0] r;
    logic        v;
    yy = sb ? ~y : y;
    cc = sb ? 1'b1 : c;
    r  = {1'b0, x} + {1'b0, yy} + {32'd0, cc};
    v  = (x[31] == yy[31]) && (r[31] != x[31]);
    return {v, r};
  endfunction

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", name, got, exp);
    end
  endtask

  // Handshake one operation and wait for the result; checks latency and result.
  task automatic issue(input logic [31:0] x, input logic [31:0] y, input logic c,
                       input logic sb, input string tag);
    logic [33:0] e;
    int k;
    e = model(x, y, c, sb);
    chk({tag, " in_ready"}, 64'(in_ready), 64'd1);
    a = x; b = y; cin = c; sub = sb; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0; a = $urandom; b = $urandom; cin = ~c; sub = ~sb;
    k = 0;
    while (!out_valid && k < 64) begin
      @(posedge clk); #1;
      k++;
    end
    chk({tag, " latency"}, 64'(k), 64'd4);
    chk({tag, " sum"}, 64'(sum), 64'(e[31:0]));
    chk({tag, " cout"}, 64'(cout), 64'(e[32]));
    chk({tag, " ovf"}, 64'(ovf), 64'(e[33]));
    $display("op %s: a=%h b=%h cin=%0d sub=%0d -> sum=%h cout=%0d ovf=%0d cycles=%0d",
             tag, x, y, c, sb, sum, cout, ovf, k);
  endtask

  task automatic release_out(input string tag);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk({tag, " out_valid after accept"}, 64'(out_valid), 64'd0);
    chk({tag, " in_ready after accept"}, 64'(in_ready), 64'd1);
  endtask

  task automatic run_op(input logic [31:0] x, input logic [31:0] y, input logic c,
                        input logic sb, input string tag);
    issue(x, y, c, sb, tag);
    release_out(tag);
  endtask

  vec_t vecs [4];

  initial begin
    logic [33:0] e;
    int k;
    vecs[0] = '{32'h0000_0001, 32'h0000_0002, 1'b0, 32'h0000_0003, 1'b0, 1'b0};
    vecs[1] = '{32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 32'h0000_0000, 1'b1, 1'b0};
    vecs[2] = '{32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 32'h8000_0000, 1'b0, 1'b1};
    vecs[3] = '{32'h0000_002F, 32'h0000_0081, 1'b1, 32'h0000_00B1, 1'b0, 1'b0};

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0; cin = 1'b0; sub = 1'b0;
    s_in_valid = 1'b0; s_out_ready = 1'b0; s_a = '0; s_b = '0; s_cin = 1'b0; s_sub = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    chk("reset in_ready", 64'(in_ready), 64'd1);
    chk("reset out_valid", 64'(out_valid), 64'd0);
    chk("reset sum", 64'(sum), 64'd0);
    chk("reset cout", 64'(cout), 64'd0);
    chk("reset ovf", 64'(ovf), 64'd0);

    // Directed table, expectations written out by hand.
    for (int i = 0; i < 4; i++) begin
      issue(vecs[i].a, vecs[i].b, vecs[i].cin, 1'b0, $sformatf("vec%0d", i));
      chk($sformatf("vec%0d table sum", i), 64'(sum), 64'(vecs[i].sum));
      chk($sformatf("vec%0d table cout", i), 64'(cout), 64'(vecs[i].cout));
      chk($sformatf("vec%0d table ovf", i), 64'(ovf), 64'(vecs[i].ovf));
      release_out($sformatf("vec%0d", i));
    end

    // Backpressure: hold result for 10 cycles while new operands are offered.
    issue(32'h1234_5678, 32'h0FED_CBA9, 1'b1, 1'b0, "bp");
    e = model(32'h1234_5678, 32'h0FED_CBA9, 1'b1, 1'b0);
    for (int i = 0; i < 10; i++) begin
      in_valid = 1'b1; a = $urandom; b = $urandom; cin = 1'b1;
      @(posedge clk); #1;
      chk("bp out_valid hold", 64'(out_valid), 64'd1);
      chk("bp in_ready low", 64'(in_ready), 64'd0);
      chk("bp sum hold", 64'(sum), 64'(e[31:0]));
    end
    in_valid = 1'b0;
    release_out("bp");
    run_op(32'h0000_0010, 32'h0000_0020, 1'b0, 1'b0, "bp_next");

    // Reset during the second BUSY cycle of an add with a carry chain.
    a = 32'hFFFF_FFFF; b = 32'h0000_0001; cin = 1'b1; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("abort out_valid", 64'(out_valid), 64'd0);
    chk("abort in_ready", 64'(in_ready), 64'd1);
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      chk("abort no result", 64'(out_valid), 64'd0);
    end
    run_op(32'd5, 32'd7, 1'b0, 1'b0, "after_abort");
    chk("after_abort twelve", 64'(model(32'd5, 32'd7, 1'b0, 1'b0) & 34'hFFFF_FFFF), 64'd12);

`ifdef CHUNKED_RCA_SUB_EN
    issue(32'd10, 32'd3, 1'b0, 1'b1, "sub10_3");
    chk("sub10_3 sum", 64'(sum), 64'd7);
    chk("sub10_3 cout", 64'(cout), 64'd1);
    release_out("sub10_3");
    issue(32'd3, 32'd10, 1'b1, 1'b1, "sub3_10");
    chk("sub3_10 sum", 64'(sum), 64'hFFFF_FFF9);
    chk("sub3_10 cout", 64'(cout), 64'd0);
    release_out("sub3_10");
`endif

    // Randomized operations against the reference model.
    for (int i = 0; i < 24; i++) begin
      logic [31:0] x, y;
      logic c, sb;
      x  = $urandom;
      y  = $urandom;
      if (i % 4 == 0) y = ~x;
      c  = 1'($urandom_range(0, 1));
`ifdef CHUNKED_RCA_SUB_EN
      sb = 1'($urandom_range(0, 1));
`else
      sb = 1'b0;
`endif
      run_op(x, y, c, sb, $sformatf("rnd%0d", i));
    end

    // Narrow instance: one bit per cycle, eight-cycle latency.
    chk("narrow in_ready", 64'(s_in_ready), 64'd1);
    s_a = 8'h01; s_b = 8'h02; s_cin = 1'b0; s_in_valid = 1'b1;
    @(posedge clk); #1;
    s_in_valid = 1'b0; s_a = 8'hFF; s_b = 8'hFF; s_cin = 1'b1;
    k = 0;
    while (!s_out_valid && k < 64) begin
      @(posedge clk); #1;
      k++;
    end
    chk("narrow latency", 64'(k), 64'd8);
    chk("narrow sum", 64'(s_sum), 64'h03);
    chk("narrow cout", 64'(s_cout), 64'd0);
    chk("narrow ovf", 64'(s_ovf), 64'd0);
    $display("op narrow: a=01 b=02 cin=0 -> sum=%h cout=%0d ovf=%0d cycles=%0d",
             s_sum, s_cout, s_ovf, k);
    s_out_ready = 1'b1;
    @(posedge clk); #1;
    s_out_ready = 1'b0;
    chk("narrow release", 64'(s_out_valid), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
